// File: rtl/fft_sample_framer.sv
// fft_sample_framer: captures strobed pin samples into N-point ping-pong frames and streams each frame in index order.
// Latency: pin strobe edge -> write pulse after 2-3 clk edges; final write pulse -> m_valid after 1 clk; frames back-to-back.
// Backpressure: m_ready low holds the current beat; writes into a bank that is FULL or DRAINING are dropped and set overflow.
module fft_sample_framer #(
  parameter int N_POINTS = 8,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = $clog2(N_POINTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_strobe,
  input  logic [DATA_W-1:0] din,
  input  logic              clear,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last,
  output logic              overflow,
  output logic [3:0]        frame_count
);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_st_e;

  localparam logic [ADDR_W-1:0] FIRST_IDX = '0;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_POINTS - 1);

  // strobe synchronizer and edge-detect history
  logic sync1_q;
  logic sync2_q;
  logic sync3_q;
  logic wr_pulse;

  // ping-pong sample storage and per-bank state
  logic [DATA_W-1:0] mem_q [2][N_POINTS];
  bank_st_e          bank_q [2];
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic [ADDR_W-1:0] wr_ptr_q;

  // registered output stage
  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;
  logic [ADDR_W-1:0] m_index_q;
  logic              m_last_q;
  logic              overflow_q;
  logic [3:0]        frame_count_q;

  // per-cycle decisions
  logic              wr_open;
  logic              wr_accept;
  logic              wr_drop;
  logic              wr_complete;
  logic              beat_xfer;
  logic              nxt_bank;
  logic              rd_ready;
  logic              nxt_ready;
  logic [ADDR_W-1:0] idx_inc;

  // two-flop synchronizer plus one history flop for rising-edge detection; clear leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= wr_strobe;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign wr_pulse    = sync2_q & ~sync3_q;
  assign wr_open     = (bank_q[wr_bank_q] == BANK_EMPTY) || (bank_q[wr_bank_q] == BANK_FILLING);
  assign wr_accept   = wr_pulse && ena && !clear && wr_open;
  assign wr_drop     = wr_pulse && ena && !clear && !wr_open;
  assign wr_complete = wr_accept && (wr_ptr_q == LAST_IDX);
  assign beat_xfer   = m_valid_q && m_ready;
  assign nxt_bank    = ~rd_bank_q;
  assign idx_inc     = m_index_q + 1'b1;
  // a bank can start draining if it is already FULL or its final sample lands this very cycle;
  // sample 0 of a completing bank was written long before, so reading it now is safe
  assign rd_ready    = (bank_q[rd_bank_q] == BANK_FULL) || (wr_complete && (wr_bank_q == rd_bank_q));
  assign nxt_ready   = (bank_q[nxt_bank] == BANK_FULL) || (wr_complete && (wr_bank_q == nxt_bank));

  // sample storage; contents need no reset because bank state gates every read
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_bank_q][wr_ptr_q] <= din;
    end
  end

  // bank state machine, write pointer, flags and the registered output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[1'b0]  <= BANK_EMPTY;
      bank_q[1'b1]  <= BANK_EMPTY;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_ptr_q      <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_index_q     <= '0;
      m_last_q      <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else if (clear) begin
      bank_q[1'b0]  <= BANK_EMPTY;
      bank_q[1'b1]  <= BANK_EMPTY;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_ptr_q      <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_index_q     <= '0;
      m_last_q      <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      // write side: fill the current bank, hand it over when the last slot is written
      if (wr_accept) begin
        if (wr_complete) begin
          bank_q[wr_bank_q] <= BANK_FULL;
          wr_bank_q         <= ~wr_bank_q;
          wr_ptr_q          <= '0;
        end else begin
          bank_q[wr_bank_q] <= BANK_FILLING;
          wr_ptr_q          <= wr_ptr_q + 1'b1;
        end
      end
      if (wr_drop) begin
        overflow_q <= 1'b1;
      end

      // read side: assignments below come later so a bank that completes and starts draining
      // in the same cycle ends up DRAINING rather than FULL
      if (!m_valid_q) begin
        if (rd_ready) begin
          bank_q[rd_bank_q] <= BANK_DRAINING;
          m_valid_q         <= 1'b1;
          m_index_q         <= FIRST_IDX;
          m_data_q          <= mem_q[rd_bank_q][FIRST_IDX];
          m_last_q          <= 1'b0;
        end
      end else if (beat_xfer) begin
        if (m_last_q) begin
          bank_q[rd_bank_q] <= BANK_EMPTY;
          rd_bank_q         <= nxt_bank;
          frame_count_q     <= frame_count_q + 4'd1;
          if (nxt_ready) begin
            bank_q[nxt_bank] <= BANK_DRAINING;
            m_index_q        <= FIRST_IDX;
            m_data_q         <= mem_q[nxt_bank][FIRST_IDX];
            m_last_q         <= 1'b0;
          end else begin
            m_valid_q <= 1'b0;
          end
        end else begin
          m_index_q <= idx_inc;
          m_data_q  <= mem_q[rd_bank_q][idx_inc];
          m_last_q  <= (idx_inc == LAST_IDX);
        end
      end
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_index     = m_index_q;
  assign m_last      = m_last_q;
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;

endmodule
